// File: rtl/key_event_encoder_pkg.sv
// Shared types for the key event encoder: default key count and index width,
// the event FSM state encoding and the latched event record.
package keyenc_pkg;
  localparam int NKEYS = 21;
  localparam int KEY_W = $clog2(NKEYS);

  typedef enum logic {IDLE = 1'b0, OUT = 1'b1} keyenc_state_t;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic             press;
  } key_evt_t;
endpackage

// File: rtl/key_event_encoder_if.sv
// Press/release event handshake: one key per transfer on valid & ready.
interface key_evt_if #(parameter int KEY_W = keyenc_pkg::KEY_W);
  logic             evt_valid;
  logic             evt_ready;
  logic [KEY_W-1:0] evt_key;
  logic             evt_press;

  modport master (output evt_valid, evt_key, evt_press, input evt_ready);
  modport slave  (input evt_valid, evt_key, evt_press, output evt_ready);
endinterface

// File: rtl/key_event_encoder_debounce.sv
// One key line: 2-flop synchronizer, sample history advanced on tick, and a
// stable level that only flips once the whole history agrees.
module key_debounce #(
  parameter int DB_SAMPLES = 4
) (
  input  logic hwclk,
  input  logic nrst,
  input  logic tick,
  input  logic pb,
  output logic stable
);
  logic [1:0]            sync_q;
  logic [DB_SAMPLES-1:0] hist_q;
  logic [DB_SAMPLES-1:0] hist_d;

  // decision is taken on the history including the sample shifted in now
  assign hist_d = {hist_q[DB_SAMPLES-2:0], sync_q[1]};

  // synchronize every cycle, sample and decide only on tick
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
      hist_q <= '0;
      stable <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pb};
      if (tick) begin
        hist_q <= hist_d;
        if (&hist_d)       stable <= 1'b1;
        else if (~|hist_d) stable <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/key_event_encoder.sv
// Key event encoder: debounces NKEYS button lines and serializes level
// changes into press/release events on a valid/ready handshake.
// Optional KEYENC_ROUND_ROBIN_EN selects round-robin arbitration starting
// after the last accepted key; otherwise the lowest pending index wins.
module key_event_encoder
  import keyenc_pkg::*;
#(
  parameter int NKEYS      = keyenc_pkg::NKEYS,
  parameter int KEY_W      = $clog2(NKEYS),
  parameter int TICK_DIV   = 1000,
  parameter int DB_SAMPLES = 4
) (
  input  logic             hwclk,
  input  logic             nrst,
  input  logic [NKEYS-1:0] pb,
  output logic [NKEYS-1:0] held,
  key_evt_if.master        evt
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]    pre_q;
  logic             tick;
  logic [NKEYS-1:0] stable;
  logic [NKEYS-1:0] reported_q, reported_d;
  logic [NKEYS-1:0] pending;
  logic [KEY_W-1:0] sel;
  logic             found;
  keyenc_state_t    state_q, state_d;
  key_evt_t         evt_q, evt_d;
  logic             xfer;

  assign tick = (pre_q == PW'(TICK_DIV-1));

  // free-running sample prescaler
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst)     pre_q <= '0;
    else if (tick) pre_q <= '0;
    else           pre_q <= pre_q + 1'b1;
  end

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db (
      .hwclk (hwclk),
      .nrst  (nrst),
      .tick  (tick),
      .pb    (pb[i]),
      .stable(stable[i])
    );
  end

  assign held    = stable;
  // a key that bounced back to its reported level drops out by itself
  assign pending = stable ^ reported_q;
  assign xfer    = (state_q == OUT) && evt.evt_ready;

`ifdef KEYENC_ROUND_ROBIN_EN
  logic [KEY_W-1:0] rr_ptr_q;
  logic [KEY_W-1:0] rr_start;
  int               idx;

  // rotating search beginning just after the last accepted key
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    idx      = 0;
    rr_start = (rr_ptr_q == KEY_W'(NKEYS-1)) ? '0 : rr_ptr_q + 1'b1;
    for (int i = 0; i < NKEYS; i++) begin
      idx = int'(rr_start) + i;
      if (idx >= NKEYS) idx = idx - NKEYS;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = KEY_W'(idx);
      end
    end
  end

  // pointer follows accepted events only
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst)     rr_ptr_q <= '0;
    else if (xfer) rr_ptr_q <= evt_q.key;
  end
`else
  // fixed priority: scan downward so the lowest pending index wins
  always_comb begin
    sel   = '0;
    found = |pending;
    for (int i = NKEYS-1; i >= 0; i--)
      if (pending[i]) sel = KEY_W'(i);
  end
`endif

  // FSM next state, event latch and reported-level update
  always_comb begin
    state_d    = state_q;
    evt_d      = evt_q;
    reported_d = reported_q;
    case (state_q)
      IDLE: if (found) begin
        evt_d.key   = sel;
        evt_d.press = stable[sel];
        state_d     = OUT;
      end
      OUT: if (evt.evt_ready) begin
        reported_d[evt_q.key] = evt_q.press;
        state_d               = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and event registers; reset discards any event in flight
  always_ff @(posedge hwclk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      evt_q      <= '0;
      reported_q <= '0;
    end else begin
      state_q    <= state_d;
      evt_q      <= evt_d;
      reported_q <= reported_d;
    end
  end

  assign evt.evt_valid = (state_q == OUT);
  assign evt.evt_key   = evt_q.key;
  assign evt.evt_press = evt_q.press;
endmodule

// File: doc/key_event_encoder.md
# key_event_encoder

Input-side front end of the synthesizer: samples the 21 push-button key lines arriving from the breakout pins, synchronizes and debounces each one, and converts level changes into a serialized stream of press/release events for the note/voice logic. It is the consuming end of the button bus that `top` receives on `pb`, and it sits between the pin interface and the voice allocator. Events leave on a valid/ready handshake, one key per transfer.

## Interface
- `NKEYS`, 21, number of key inputs
- `KEY_W`, 5, width of key index (`$clog2(NKEYS)`)
- `TICK_DIV`, 1000, hwclk cycles per debounce sample tick (≥2)
- `DB_SAMPLES`, 4, consecutive equal samples required to accept a new level (≥2)

- `hwclk`  in  1  system clock
- `nrst`  in  1  asynchronous, active-low reset
- `pb`  in  NKEYS  raw key lines, active high, asynchronous to hwclk
- `evt_valid`  out  1  event presented
- `evt_ready`  in  1  consumer accepts event this cycle
- `evt_key`  out  KEY_W  index of key that changed
- `evt_press`  out  1  1 = press, 0 = release
- `held`  out  NKEYS  debounced key levels

## Operation
- Synchronizer: 2 flops per key.
- Prescaler: counts 0..TICK_DIV-1; `tick` asserted for one cycle when count = TICK_DIV-1, then wraps to 0.
- Debounce, per key, on `tick`: shift synchronized level into DB_SAMPLES-bit history; if history is all ones, `stable`←1; if all zeros, `stable`←0; otherwise hold. `held` = `stable`.
- `reported[NKEYS]` holds last level delivered to consumer. `pending = stable ^ reported`.
- FSM:
  - IDLE: if `pending` ≠ 0, select a key (arbitration below), latch `evt_key` and `evt_press = stable[key]`, go to OUT.
  - OUT: `evt_valid`=1; outputs frozen. On `evt_ready`: `reported[evt_key]` ← `evt_press`, go to IDLE.
- Key that bounces back to its reported level before selection produces no event (pending clears by itself).
- Key that changes again while its own event sits in OUT: the latched event is still delivered; the new difference re-raises `pending` and produces a further event.
- Default arbitration: fixed priority, lowest index wins.
- Reset mid-operation: everything returns to reset values; any event in OUT is discarded; consumer sees `evt_valid` drop asynchronously.

## Timing
- Reset values: `evt_valid`=0, `evt_key`=0, `evt_press`=0, `held`=0; internally `stable`, `reported`, histories, prescaler = 0, FSM = IDLE.
- `stable` updates on the clock edge where `tick`=1; IDLE→OUT on the following edge, so `evt_valid` rises one cycle after `held` changes.
- Minimum input-to-`held` latency: 2 sync cycles + (DB_SAMPLES-1)·TICK_DIV to DB_SAMPLES·TICK_DIV cycles, depending on tick phase.
- Transfer occurs on a cycle with `evt_valid & evt_ready`. `evt_valid` is not deasserted without a transfer except by reset. One event per 2 cycles maximum (OUT→IDLE→OUT).
- `evt_ready` may be high in advance; no combinational path from `evt_ready` to outputs.

## Configuration
- `KEYENC_ROUND_ROBIN_EN` defined: round-robin arbitration; search starts at index after last accepted `evt_key`, wrapping NKEYS-1→0; pointer resets to 0.
- Undefined: fixed lowest-index priority; no pointer register.

## Structure
- `keyenc_pkg`: `NKEYS`, `KEY_W` defaults, FSM state enum `keyenc_state_t` {IDLE, OUT}, event struct `key_evt_t` {key, press}.
- Sub-module `key_debounce` (sync + history + stable for one key, `tick` input), instantiated NKEYS times via generate. Prescaler, pending/arbiter, FSM in top of block.

## Test plan
(bench uses TICK_DIV=4, DB_SAMPLES=4)
- Clean press of `pb[7]` held 40 cycles -> `held[7]`=1 within 2+16 cycles; one event key=7 press=1 one cycle later; release -> key=7 press=0.
- `pb[2]` pulses high for 6 cycles (shorter than window) -> `held` stays 0, no event.
- `pb[3]` and `pb[17]` rise same cycle, `evt_ready`=1 -> events key=3 then key=17, 2 cycles apart; with `KEYENC_ROUND_ROBIN_EN` after prior key 5 accepted -> 17 first, then 3.
- `evt_ready`=0 for 50 cycles with key 9 pressed -> `evt_valid`, key=9, press=1 held stable throughout; single transfer when ready rises.
- Key 4 pressed and released while key 1 event stalls in OUT -> after key 1 accepted, no event for key 4 unless its press was already latched.
- Assert `nrst` low while in OUT -> `evt_valid`, `held` go 0 immediately; after release, no stale event; held key re-reported as press after debounce.
